// File: rtl/nrf2401_pkg.sv
// Shared definitions for the nRF2401 serial shifter.
// Holds the register map addresses, the STATUS/CTRL bit positions and the
// shifter FSM state encoding.
package nrf2401_pkg;

  // Register map
  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RXDATA = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_RX_VALID = 2;
  localparam int unsigned STAT_OVERRUN  = 3;

  // CTRL bit positions (div occupies bits [DIV_W-1:0])
  localparam int unsigned CTRL_RX_MODE = 14;
  localparam int unsigned CTRL_IRQ_EN  = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/nrf2401_clkdiv.sv
// Half-period tick generator for the nRF2401 serial clock.
// A down-counter reloaded with div; tick is high for the one cycle in which
// the counter reads zero, so consecutive ticks are div+1 cycles apart.
//   clk, reset : system clock, synchronous active-high reset
//   restart    : reload the counter from div (aligns the first half-period)
//   div        : reload value
//   tick       : one-cycle half-period strobe
module nrf2401_clkdiv #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/nrf2401_shifter.sv
// Memory-mapped 8-bit serial shifter driving an nRF2401 CLK1/DATA pin pair.
//   clk, reset           : system clock, synchronous active-high reset
//   address, chipselect,
//   write_n, read_n,
//   writedata, readdata  : slave register port (TXDATA, STATUS, RXDATA, CTRL)
//   rf_clk               : nRF2401 CLK1
//   rf_dout, rf_oe       : DATA pin drive value and output enable
//   rf_din               : DATA pin sampled value (pre-synchronised)
//   irq                  : done & irq_en
module nrf2401_shifter #(
  parameter int unsigned DIV_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        rf_clk,
  output logic        rf_dout,
  output logic        rf_oe,
  input  logic        rf_din,
  output logic        irq
);

  import nrf2401_pkg::*;

  state_t           state;
  logic [7:0]       shift;
  logic [7:0]       rxdata;
  logic [2:0]       bit_cnt;
  logic             rx_bit;
  logic [DIV_W-1:0] ctrl_div;
  logic             ctrl_rx_mode;
  logic             ctrl_irq_en;
  logic [DIV_W-1:0] div_lat;
  logic             rx_mode_lat;
  logic             done;
  logic             rx_valid;
  logic             overrun;

  logic             wr;
  logic             rd;
  logic             busy;
  logic             start;
  logic             tick;
  logic [DIV_W-1:0] reload;
  logic             shifting;

  assign wr       = chipselect & ~write_n;
  assign rd       = chipselect & ~read_n;
  assign busy     = (state != ST_IDLE);
  assign start    = wr && (address == ADDR_TXDATA) && (state == ST_IDLE);
  assign shifting = (state == ST_LOW) || (state == ST_HIGH);

  // The latched divisor is only written on the start edge, so the first
  // half-period has to be loaded straight from CTRL.
  assign reload = start ? ctrl_div : div_lat;

  nrf2401_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk     (clk),
    .reset   (reset),
    .restart (start),
    .div     (reload),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      shift        <= '0;
      rxdata       <= '0;
      bit_cnt      <= '0;
      rx_bit       <= 1'b0;
      ctrl_div     <= '0;
      ctrl_rx_mode <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      div_lat      <= '0;
      rx_mode_lat  <= 1'b0;
      done         <= 1'b0;
      rx_valid     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (wr && address == ADDR_CTRL) begin
        ctrl_div     <= writedata[DIV_W-1:0];
        ctrl_rx_mode <= writedata[CTRL_RX_MODE];
        ctrl_irq_en  <= writedata[CTRL_IRQ_EN];
      end
      if (wr && address == ADDR_STATUS) begin
        done    <= 1'b0;
        overrun <= 1'b0;
      end
      if (rd && address == ADDR_RXDATA) begin
        rx_valid <= 1'b0;
      end

      // FSM updates come last so a FIN set wins over a same-cycle clear.
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift       <= writedata[7:0];
            done        <= 1'b0;
            div_lat     <= ctrl_div;
            rx_mode_lat <= ctrl_rx_mode;
            bit_cnt     <= '0;
            state       <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tick) begin
            // Captured on the edge that raises rf_clk, shifted in at the
            // end of HIGH so shift[7] stays stable for the whole bit.
            rx_bit <= rf_din;
            state  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            shift   <= {shift[6:0], rx_bit};
            bit_cnt <= bit_cnt + 3'd1;
            state   <= (bit_cnt == 3'd7) ? ST_FIN : ST_LOW;
          end
        end
        ST_FIN: begin
          rxdata   <= shift;
          done     <= 1'b1;
          rx_valid <= 1'b1;
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rf_clk  = (state == ST_HIGH);
  assign rf_dout = shifting & shift[7];
  assign rf_oe   = shifting & ~rx_mode_lat;
  assign irq     = done & ctrl_irq_en;

  logic [15:0] status_rd;
  logic [15:0] ctrl_rd;

  always_comb begin
    status_rd                = '0;
    status_rd[STAT_BUSY]     = busy;
    status_rd[STAT_DONE]     = done;
    status_rd[STAT_RX_VALID] = rx_valid;
    status_rd[STAT_OVERRUN]  = overrun;
  end

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[DIV_W-1:0]    = ctrl_div;
    ctrl_rd[CTRL_RX_MODE] = ctrl_rx_mode;
    ctrl_rd[CTRL_IRQ_EN]  = ctrl_irq_en;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_TXDATA: readdata = {8'h00, shift};
      ADDR_STATUS: readdata = status_rd;
      ADDR_RXDATA: readdata = {8'h00, rxdata};
      ADDR_CTRL:   readdata = ctrl_rd;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nrf2401_shifter.sv
// Directed self-checking bench for nrf2401_shifter.
module tb_nrf2401_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        rf_clk;
  logic        rf_dout;
  logic        rf_oe;
  logic        rf_din;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nrf2401_shifter #(.DIV_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .rf_clk     (rf_clk),
    .rf_dout    (rf_dout),
    .rf_oe      (rf_oe),
    .rf_din     (rf_din),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address    = addr;
    chipselect = 1'b1;
    read_n     = 1'b0;
    #1;
    data = 32'(readdata);
    @(negedge clk);
    read_n     = 1'b1;
    chipselect = 1'b0;
  endtask

  // Called at the negedge right after the TXDATA write edge. Polls STATUS.busy
  // every cycle, feeds rxb MSB first on rf_din and records pin activity.
  task automatic run_xfer(input logic [7:0] rxb, input int div, input int inject,
                          output int busy_cyc, output logic [7:0] txbits,
                          output int oe_cyc, output int nruns, output int badruns,
                          output int irq_cyc, output bit timeout);
    logic prev_clk = 1'b0;
    int   run = 0;
    int   rises = 0;
    busy_cyc = 0; txbits = '0; oe_cyc = 0; nruns = 0; badruns = 0; irq_cyc = 0;
    timeout = 1'b1;
    chipselect = 1'b1;
    read_n     = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == inject) begin
        address   = 2'd0;
        writedata = 16'h00FF;
        write_n   = 1'b0;
      end else begin
        address = 2'd1;
        write_n = 1'b1;
      end
      rf_din = (rises < 8) ? rxb[7-rises] : 1'b0;
      #1;
      if (i != inject && readdata[0] == 1'b0) begin
        timeout = 1'b0;
        break;
      end
      busy_cyc++;
      if (rf_oe) oe_cyc++;
      if (irq) irq_cyc++;
      if (rf_clk != prev_clk) begin
        nruns++;
        if (run != div + 1) badruns++;
        run = 0;
        if (rf_clk) begin
          txbits = {txbits[6:0], rf_dout};
          rises++;
        end
      end
      run++;
      prev_clk = rf_clk;
      @(negedge clk);
    end
    write_n    = 1'b1;
    chipselect = 1'b0;
    address    = 2'd1;
  endtask

  logic [31:0] rd;
  int          busy_cyc, oe_cyc, nruns, badruns, irq_cyc;
  logic [7:0]  txbits;
  bit          timeout;

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    writedata = '0; rf_din = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_rf_clk", 32'(rf_clk), 0);
    check("rst_rf_dout", 32'(rf_dout), 0);
    check("rst_rf_oe", 32'(rf_oe), 0);
    check("rst_irq", 32'(irq), 0);
    bus_read(2'd1, rd); check("rst_status", rd, 32'h0);
    bus_read(2'd3, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(2'd2, rd); check("rst_rxdata", rd, 32'h0);
    bus_read(2'd0, rd); check("rst_txdata", rd, 32'h0);

    // div=0 transmit 0xA5, loopback byte 0x5A on rf_din
    bus_write(2'd3, 16'h0000);
    bus_write(2'd0, 16'h00A5);
    run_xfer(8'h5A, 0, -1, busy_cyc, txbits, oe_cyc, nruns, badruns, irq_cyc, timeout);
    check("a_timeout", 32'(timeout), 0);
    check("a_txbits", 32'(txbits), 32'hA5);
    check("a_busy", 32'(busy_cyc), 17);
    check("a_oe", 32'(oe_cyc), 16);
    check("a_runs", 32'(nruns), 16);
    check("a_badruns", 32'(badruns), 0);
    bus_read(2'd1, rd); check("a_status", rd, 32'h06);
    bus_read(2'd0, rd); check("a_txdata", rd, 32'h5A);
    bus_read(2'd2, rd); check("a_rxdata", rd, 32'h5A);
    bus_read(2'd1, rd); check("a_status_rdclr", rd, 32'h02);

    // div=3 receive 0x3C
    bus_write(2'd3, 16'h4003);
    bus_read(2'd3, rd); check("b_ctrl", rd, 32'h4003);
    bus_write(2'd0, 16'h0000);
    run_xfer(8'h3C, 3, -1, busy_cyc, txbits, oe_cyc, nruns, badruns, irq_cyc, timeout);
    check("b_timeout", 32'(timeout), 0);
    check("b_busy", 32'(busy_cyc), 65);
    check("b_oe", 32'(oe_cyc), 0);
    check("b_runs", 32'(nruns), 16);
    check("b_badruns", 32'(badruns), 0);
    check("b_txbits", 32'(txbits), 32'h00);
    bus_read(2'd1, rd); check("b_status", rd, 32'h06);

    // second receive without reading RXDATA -> overrun
    bus_write(2'd3, 16'h4000);
    bus_write(2'd0, 16'h0000);
    run_xfer(8'h81, 0, -1, busy_cyc, txbits, oe_cyc, nruns, badruns, irq_cyc, timeout);
    check("c_timeout", 32'(timeout), 0);
    check("c_busy", 32'(busy_cyc), 17);
    bus_read(2'd1, rd); check("c_status_ovr", rd, 32'h0E);
    bus_write(2'd1, 16'h0000);
    bus_read(2'd1, rd); check("c_status_wrclr", rd, 32'h04);
    bus_read(2'd2, rd); check("c_rxdata", rd, 32'h81);
    bus_read(2'd1, rd); check("c_status_rdclr", rd, 32'h00);

    // div=1 transmit 0x12 with a TXDATA write of 0xFF mid-transfer
    bus_write(2'd3, 16'h0001);
    bus_write(2'd0, 16'h0012);
    run_xfer(8'h00, 1, 10, busy_cyc, txbits, oe_cyc, nruns, badruns, irq_cyc, timeout);
    check("d_timeout", 32'(timeout), 0);
    check("d_txbits", 32'(txbits), 32'h12);
    check("d_busy", 32'(busy_cyc), 33);
    check("d_oe", 32'(oe_cyc), 32);
    check("d_badruns", 32'(badruns), 0);
    bus_read(2'd1, rd); check("d_status", rd, 32'h06);
    bus_read(2'd2, rd); check("d_rxdata", rd, 32'h00);

    // irq follows done when irq_en=1
    bus_write(2'd1, 16'h0000);
    bus_write(2'd3, 16'h8000);
    check("e_irq_idle", 32'(irq), 0);
    bus_write(2'd0, 16'h0055);
    run_xfer(8'h00, 0, -1, busy_cyc, txbits, oe_cyc, nruns, badruns, irq_cyc, timeout);
    check("e_timeout", 32'(timeout), 0);
    check("e_irq_busy", 32'(irq_cyc), 0);
    check("e_irq_done", 32'(irq), 1);
    check("e_txbits", 32'(txbits), 32'h55);
    bus_write(2'd1, 16'h0000);
    check("e_irq_clr", 32'(irq), 0);

    // reset after bit 3 of a transfer
    bus_write(2'd3, 16'h0000);
    bus_write(2'd0, 16'h00F0);
    begin
      logic prev = 1'b0;
      int   rises = 0;
      for (int i = 0; i < 200; i++) begin
        if (rf_clk && !prev) rises++;
        prev = rf_clk;
        if (rises == 4) break;
        @(negedge clk);
      end
      check("f_reached_bit3", 32'(rises), 4);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("f_rf_clk", 32'(rf_clk), 0);
    check("f_rf_oe", 32'(rf_oe), 0);
    bus_read(2'd1, rd); check("f_status", rd, 32'h00);
    bus_read(2'd2, rd); check("f_rxdata", rd, 32'h00);
    repeat (30) @(negedge clk);
    bus_read(2'd1, rd); check("f_status_late", rd, 32'h00);
    bus_read(2'd2, rd); check("f_rxdata_late", rd, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
